// File: rtl/prbs31_burst_sched_if.sv
// Command/status bundle between the user command pins, the burst scheduler and the
// PRBS31 generator strobes.
interface prbs31_burst_sched_if #(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [LEN_W-1:0] burst_len;
    logic [LEN_W-1:0] gap_len;
    logic [CNT_W-1:0] num_bursts;
    logic             reseed;
    logic             out_ready;

    logic             gen_load;
    logic             gen_en;
    logic             busy;
    logic             burst_active;
    logic             done;
    logic             aborted;
    logic [LEN_W-1:0] beats_left;
    logic [CNT_W-1:0] bursts_left;

    modport master (
        output start, stop, burst_len, gap_len, num_bursts, reseed, out_ready,
        input  gen_load, gen_en, busy, burst_active, done, aborted, beats_left, bursts_left
    );

    modport slave (
        input  start, stop, burst_len, gap_len, num_bursts, reseed, out_ready,
        output gen_load, gen_en, busy, burst_active, done, aborted, beats_left, bursts_left
    );
endinterface

// File: rtl/prbs31_burst_sched.sv
// Burst scheduler for the PRBS31 generator: seed load, timed bursts of gen_en beats,
// idle gaps between bursts, back-pressure from out_ready and abort via stop.
module prbs31_burst_sched #(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    prbs31_burst_sched_if.slave bus
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StBurst = 3'd2;
    localparam logic [2:0] StGap   = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] burst_len_q, burst_len_d;
    logic [LEN_W-1:0] gap_len_q, gap_len_d;
    logic             reseed_q, reseed_d;
    logic [LEN_W-1:0] beats_q, beats_d;
    logic [CNT_W-1:0] bursts_q, bursts_d;
    logic [LEN_W-1:0] gap_q, gap_d;
    logic             aborted_q, aborted_d;

    logic running;
    logic beat_fire;

    assign running   = (state_q == StLoad) || (state_q == StBurst) || (state_q == StGap);
    // stop masks the beat in the same cycle so no bit escapes on the abort edge
    assign beat_fire = (state_q == StBurst) && bus.out_ready && !bus.stop;

    always_comb begin
        state_d     = state_q;
        burst_len_d = burst_len_q;
        gap_len_d   = gap_len_q;
        reseed_d    = reseed_q;
        beats_d     = beats_q;
        bursts_d    = bursts_q;
        gap_d       = gap_q;
        aborted_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    burst_len_d = bus.burst_len;
                    gap_len_d   = bus.gap_len;
                    reseed_d    = bus.reseed;
                    if ((bus.burst_len == '0) || (bus.num_bursts == '0)) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StLoad;
                        beats_d  = bus.burst_len;
                        bursts_d = bus.num_bursts;
                    end
                end
            end

            StLoad: begin
                state_d = StBurst;
                beats_d = burst_len_q;
            end

            StBurst: begin
                if (beat_fire) begin
                    if (beats_q == LenOne) begin
                        if (bursts_q == CntOne) begin
                            state_d  = StDone;
                            beats_d  = '0;
                            bursts_d = '0;
                        end else begin
                            bursts_d = bursts_q - CntOne;
                            if (gap_len_q != '0) begin
                                state_d = StGap;
                                gap_d   = gap_len_q;
                                beats_d = '0;
                            end else if (reseed_q) begin
                                state_d = StLoad;
                                beats_d = burst_len_q;
                            end else begin
                                // back-to-back burst: generator keeps running, no idle cycle
                                beats_d = burst_len_q;
                            end
                        end
                    end else begin
                        beats_d = beats_q - LenOne;
                    end
                end
            end

            StGap: begin
                if (gap_q == LenOne) begin
                    gap_d   = '0;
                    beats_d = burst_len_q;
                    state_d = reseed_q ? StLoad : StBurst;
                end else begin
                    gap_d = gap_q - LenOne;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d  = StIdle;
                beats_d  = '0;
                bursts_d = '0;
                gap_d    = '0;
            end
        endcase

        if (running && bus.stop) begin
            state_d   = StDone;
            aborted_d = 1'b1;
            beats_d   = '0;
            bursts_d  = '0;
            gap_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            burst_len_q <= '0;
            gap_len_q   <= '0;
            reseed_q    <= 1'b0;
            beats_q     <= '0;
            bursts_q    <= '0;
            gap_q       <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_len_q <= burst_len_d;
            gap_len_q   <= gap_len_d;
            reseed_q    <= reseed_d;
            beats_q     <= beats_d;
            bursts_q    <= bursts_d;
            gap_q       <= gap_d;
            aborted_q   <= aborted_d;
        end
    end

    // aborted_q is only ever set on entry to DONE, which lasts one cycle
    assign bus.gen_load     = (state_q == StLoad);
    assign bus.gen_en       = beat_fire;
    assign bus.busy         = (state_q != StIdle);
    assign bus.burst_active = (state_q == StBurst);
    assign bus.done         = (state_q == StDone);
    assign bus.aborted      = aborted_q;
    assign bus.beats_left   = beats_q;
    assign bus.bursts_left  = bursts_q;

endmodule
